// File: rtl/window_gen_3x3.sv
// Streams IMG_W 3x3x3 windows per held padded row triple, then pulses wait_en to release the row stage.
// Optional row/frame counter enabled by defining WINGEN_ROW_CNT_EN.
module window_gen_3x3 #(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rows_valid,
  input  logic [(IMG_W+2)*DW-1:0]      R_row0,
  input  logic [(IMG_W+2)*DW-1:0]      R_row1,
  input  logic [(IMG_W+2)*DW-1:0]      R_row2,
  input  logic [(IMG_W+2)*DW-1:0]      G_row0,
  input  logic [(IMG_W+2)*DW-1:0]      G_row1,
  input  logic [(IMG_W+2)*DW-1:0]      G_row2,
  input  logic [(IMG_W+2)*DW-1:0]      B_row0,
  input  logic [(IMG_W+2)*DW-1:0]      B_row1,
  input  logic [(IMG_W+2)*DW-1:0]      B_row2,
  output logic                         wait_en,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [9*DW-1:0]              win_R,
  output logic [9*DW-1:0]              win_G,
  output logic [9*DW-1:0]              win_B,
  output logic [$clog2(IMG_W)-1:0]     col,
  output logic [$clog2(IMG_H)-1:0]     row_idx,
  output logic                         frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = (IMG_W+2)*DW;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W-1);

  typedef enum logic [1:0] {IDLE, EMIT, RELEASE, DRAIN} state_t;
  state_t state;

  logic          last;
  logic [CW:0]   next_base;

  assign last      = (col == LAST_COL);
  assign next_base = {1'b0, col} + (CW+1)'(1);

  // base never exceeds IMG_W-1, so base+2 stays inside the padded row
  function automatic logic [9*DW-1:0] pick(input logic [PW-1:0] r0,
                                           input logic [PW-1:0] r1,
                                           input logic [PW-1:0] r2,
                                           input logic [CW:0]   base);
    logic [9*DW-1:0] w;
    w = '0;
    for (int c = 0; c < 3; c++) begin
      w[c*DW     +: DW] = r0[(int'(base)+c)*DW +: DW];
      w[(3+c)*DW +: DW] = r1[(int'(base)+c)*DW +: DW];
      w[(6+c)*DW +: DW] = r2[(int'(base)+c)*DW +: DW];
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      win_valid <= 1'b0;
      wait_en   <= 1'b0;
      win_R     <= '0;
      win_G     <= '0;
      win_B     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rows_valid) begin
            state     <= EMIT;
            win_valid <= 1'b1;
            col       <= '0;
            win_R     <= pick(R_row0, R_row1, R_row2, '0);
            win_G     <= pick(G_row0, G_row1, G_row2, '0);
            win_B     <= pick(B_row0, B_row1, B_row2, '0);
          end
        end
        EMIT: begin
          if (win_ready) begin
            if (last) begin
              state     <= RELEASE;
              win_valid <= 1'b0;
              wait_en   <= 1'b1;
            end else begin
              col   <= col + CW'(1);
              win_R <= pick(R_row0, R_row1, R_row2, next_base);
              win_G <= pick(G_row0, G_row1, G_row2, next_base);
              win_B <= pick(B_row0, B_row1, B_row2, next_base);
            end
          end
        end
        RELEASE: begin
          wait_en <= 1'b0;
          state   <= DRAIN;
        end
        DRAIN: begin
          // a stale rows_valid from the previous row must not restart emission
          if (!rows_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WINGEN_ROW_CNT_EN
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H-1);

  // updated on entry to RELEASE so the new index and frame_done are visible during it
  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx    <= '0;
      frame_done <= 1'b0;
    end else if (state == EMIT && win_ready && last) begin
      if (row_idx == LAST_ROW) begin
        row_idx    <= '0;
        frame_done <= 1'b1;
      end else begin
        row_idx <= row_idx + RW'(1);
      end
    end else begin
      frame_done <= 1'b0;
    end
  end
`else
  assign row_idx    = '0;
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: table of row runs with a scoreboard of expected windows,
// plus hand-written latency, stale-flag and mid-row reset sequences.
module tb_window_gen_3x3;
  localparam int W  = 416;
`ifdef WINGEN_ROW_CNT_EN
  localparam int H  = 4;
`else
  localparam int H  = 416;
`endif
  localparam int DW = 8;
  localparam int PW = (W+2)*DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rows_valid = 1'b0;
  logic win_ready = 1'b1;
  logic [PW-1:0] rr [3];
  logic [PW-1:0] gg [3];
  logic [PW-1:0] bb [3];
  logic wait_en, win_valid, frame_done;
  logic [9*DW-1:0] win_R, win_G, win_B;
  logic [$clog2(W)-1:0] col;
  logic [$clog2(H)-1:0] row_idx;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .reset(reset), .rows_valid(rows_valid),
    .R_row0(rr[0]), .R_row1(rr[1]), .R_row2(rr[2]),
    .G_row0(gg[0]), .G_row1(gg[1]), .G_row2(gg[2]),
    .B_row0(bb[0]), .B_row1(bb[1]), .B_row2(bb[2]),
    .wait_en(wait_en), .win_valid(win_valid), .win_ready(win_ready),
    .win_R(win_R), .win_G(win_G), .win_B(win_B),
    .col(col), .row_idx(row_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  c;
    logic [71:0] r;
    logic [71:0] g;
    logic [71:0] b;
  } beat_t;

  typedef struct {
    int seed;
    bit rand_ready;
    int hold;
    int exp_beats;
    int exp_pulses;
  } row_vec_t;

  beat_t sb[$];
  beat_t mb;
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int wait_cnt = 0;
  int exp_row = 0;
  bit rand_ready = 1'b0;
  bit stall = 1'b0;
  logic [71:0] s_r, s_g, s_b;
  logic [8:0]  s_c;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // pixel k of row r, channel ch (0=R,1=G,2=B)
  function automatic logic [7:0] pix(input int seed, input int ch, input int r, input int k);
    return 8'((k + 16*r + seed + ch) & 255);
  endfunction

  function automatic logic [71:0] exp_win(input int seed, input int ch, input int c);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int cc = 0; cc < 3; cc++)
        w[(r*3+cc)*8 +: 8] = pix(seed, ch, r, c+cc);
    return w;
  endfunction

  task automatic set_rows(input int seed);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < W+2; k++) begin
        rr[r][k*DW +: DW] = pix(seed, 0, r, k);
        gg[r][k*DW +: DW] = pix(seed, 1, r, k);
        bb[r][k*DW +: DW] = pix(seed, 2, r, k);
      end
  endtask

  task automatic push_row(input int seed);
    beat_t e;
    for (int c = 0; c < W; c++) begin
      e.c = 9'(c);
      e.r = exp_win(seed, 0, c);
      e.g = exp_win(seed, 1, c);
      e.b = exp_win(seed, 2, c);
      sb.push_back(e);
    end
  endtask

  // ready driver
  initial forever begin
    @(posedge clk); #1;
    win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_col", 72'(col), 72'(s_c));
        check("stall_R", win_R, s_r);
        check("stall_G", win_G, s_g);
        check("stall_B", win_B, s_b);
      end
      if (win_valid && win_ready) begin
        beats++;
        if (sb.size() == 0) begin
          check("extra_beat", 72'(1), 72'(0));
        end else begin
          mb = sb.pop_front();
          check("beat_col", 72'(col), 72'(mb.c));
          check("beat_R", win_R, mb.r);
          check("beat_G", win_G, mb.g);
          check("beat_B", win_B, mb.b);
          check("beat_row_idx", 72'(row_idx), 72'(exp_row));
        end
      end
      stall = win_valid && !win_ready;
      s_c = 9'(col); s_r = win_R; s_g = win_G; s_b = win_B;
      if (wait_en) begin
        wait_cnt++;
        check("release_valid_low", 72'(win_valid), 72'(0));
`ifdef WINGEN_ROW_CNT_EN
        check("release_frame_done", 72'(frame_done), 72'(exp_row == H-1));
        exp_row = (exp_row == H-1) ? 0 : exp_row + 1;
`else
        check("release_frame_done", 72'(frame_done), 72'(0));
`endif
        check("release_row_idx", 72'(row_idx), 72'(exp_row));
      end else begin
        check("frame_done_quiet", 72'(frame_done), 72'(0));
      end
    end
  end

  task automatic run_row(input row_vec_t v);
    int b0, w0;
    bit seen;
    set_rows(v.seed);
    push_row(v.seed);
    rand_ready = v.rand_ready;
    b0 = beats;
    w0 = wait_cnt;
    @(posedge clk); #1 rows_valid = 1'b1;
    @(negedge clk); check("start_latency", 72'(win_valid), 72'(0));
    @(negedge clk); check("first_valid", 72'(win_valid), 72'(1));
    check("first_col", 72'(col), 72'(0));
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (wait_en) seen = 1'b1;
    end
    check("release_timeout", 72'(seen), 72'(1));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk); check("drain_no_emit", 72'(win_valid), 72'(0));
    end
    @(posedge clk); #1 rows_valid = 1'b0;
    @(negedge clk); check("idle_no_emit", 72'(win_valid), 72'(0));
    check("row_beats", 72'(beats - b0), 72'(v.exp_beats));
    check("wait_pulses", 72'(wait_cnt - w0), 72'(v.exp_pulses));
    check("sb_empty", 72'(sb.size()), 72'(0));
    rand_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    row_vec_t vecs [5];
    bit hit;
    vecs[0] = '{seed: 0,  rand_ready: 1'b0, hold: 1, exp_beats: W, exp_pulses: 1};
    vecs[1] = '{seed: 5,  rand_ready: 1'b1, hold: 1, exp_beats: W, exp_pulses: 1};
    vecs[2] = '{seed: 9,  rand_ready: 1'b0, hold: 3, exp_beats: W, exp_pulses: 1};
    vecs[3] = '{seed: 33, rand_ready: 1'b1, hold: 2, exp_beats: W, exp_pulses: 1};
    vecs[4] = '{seed: 77, rand_ready: 1'b0, hold: 1, exp_beats: W, exp_pulses: 1};

    set_rows(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ctrl", 72'({wait_en, win_valid, frame_done, col, row_idx}), 72'(0));
      check("idle_win", win_R | win_G | win_B, 72'(0));
    end

    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // abandon a row mid-way with reset
    set_rows(21);
    push_row(21);
    @(posedge clk); #1 rows_valid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (win_valid && col == 200) hit = 1'b1;
    end
    check("reach_col200", 72'(hit), 72'(1));
    reset = 1'b1;
    rows_valid = 1'b0;
    @(negedge clk);
    check("rst_ctrl", 72'({wait_en, win_valid, frame_done, col, row_idx}), 72'(0));
    check("rst_win", win_R | win_G | win_B, 72'(0));
    sb.delete();
    exp_row = 0;
    @(posedge clk); #1 reset = 1'b0;
    run_row('{seed: 3, rand_ready: 1'b1, hold: 1, exp_beats: W, exp_pulses: 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Sliding-window generator directly downstream of the padded three-row register stage in the YOLO CNN front end. It consumes three held padded rows per colour channel (R/G/B, (IMG_W+2) pixels each) and streams IMG_W 3x3x3 windows, one per output column, over a valid/ready interface to the convolution engine. After the last window it pulses `wait_en` to release the row register stage for the next row.

## Interface
- `IMG_W`, 416: output columns per row; input rows are IMG_W+2 pixels.
- `IMG_H`, 416: output rows per frame; used only with the row counter.
- `DW`, 8: bits per pixel.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rows_valid`  in  1  three rows below are loaded and held stable (driven by the upstream `intr`).
- `R_row0`..`R_row2`, `G_row0`..`G_row2`, `B_row0`..`B_row2`  in  (IMG_W+2)*DW each  padded rows; pixel k at bits [k*DW +: DW], k=0 is the left pad.
- `wait_en`  out  1  one-cycle release pulse to the upstream stage.
- `win_valid`  out  1  window outputs valid.
- `win_ready`  in  1  consumer accepts the window.
- `win_R`, `win_G`, `win_B`  out  9*DW each  window; element (r,c) at [(r*3+c)*DW +: DW] = row r, pixel col+c.
- `col`  out  $clog2(IMG_W)  column index of the current window.
- `row_idx`  out  $clog2(IMG_H)  output row index.
- `frame_done`  out  1  pulse after the last row of a frame.

## Operation
- States: IDLE, EMIT, RELEASE, DRAIN.
- IDLE: `win_valid`=0. If `rows_valid`=1, go to EMIT and load column 0 into the window registers.
- EMIT: `win_valid`=1. On `win_valid && win_ready`:
  - if `col` < IMG_W-1: increment `col` and load column `col`+1;
  - if `col` == IMG_W-1: go to RELEASE.
- EMIT, no handshake: hold all window outputs and `col` unchanged.
- RELEASE: `win_valid`=0, `wait_en`=1 for exactly this one cycle. Next state is DRAIN.
- DRAIN: `wait_en`=0. Stay in DRAIN while `rows_valid`=1. The upstream flag deasserts one or more cycles after the release, and a stale flag must not restart emission. Go to IDLE when `rows_valid`=0.
- `rows_valid` is ignored in EMIT and RELEASE. Input rows are not latched; the upstream stage holds them until `wait_en`.
- Window registers load only from in-range pixels col..col+2 ≤ IMG_W+1. No out-of-range access occurs.
- Reset in any state: state IDLE, `col`=0, `win_valid`=0, `wait_en`=0, window outputs 0, `row_idx`=0, `frame_done`=0. A partially emitted row is abandoned.

## Timing
- `rows_valid` sampled high in IDLE at edge N: `win_valid`=1 with column 0 from cycle N+1.
- Throughput is one window per cycle while `win_ready`=1, so a row takes IMG_W cycles.
- The accepting edge of the last window is followed by one RELEASE cycle, then at least one DRAIN cycle.
- Minimum row-to-row gap in this block is 2 cycles, plus the upstream reload time.
- All outputs are registered; no combinational path from `win_ready` to outputs.

## Configuration
- `WINGEN_ROW_CNT_EN` defined:
  - `row_idx` increments in RELEASE.
  - At `row_idx` == IMG_H-1, RELEASE instead wraps `row_idx` to 0 and pulses `frame_done` for that one cycle.
- Not defined: `row_idx` and `frame_done` are constant 0 and no counter logic is built. Ports remain present.

## Test plan
- Reset, then idle with `rows_valid`=0 → all outputs 0, state IDLE for 20 cycles.
- Rows with pixel k = k mod 256 (R), +1 (G), +2 (B); `win_ready`=1:
  - 416 consecutive beats; beat 0 `win_R` row0 = {0,1,2}; beat 415 = {415,416,417} mod 256;
  - then a single `wait_en` pulse.
- Random `win_ready` (50%) → 416 accepted beats in order with no duplicates or drops; outputs stable while stalled.
- Hold `rows_valid`=1 for 3 cycles after `wait_en` → no new emission until it drops and re-rises; second row emits from col 0.
- Assert reset at col=200 → next cycle all outputs 0; a fresh `rows_valid` restarts at col 0.
- With `WINGEN_ROW_CNT_EN`, IMG_H=4: 4 rows → `row_idx` 0,1,2,3, `frame_done` pulse in the 4th RELEASE, `row_idx` back to 0.
